// File: rtl/xylo_seg_encoder.sv
// xylo_seg_encoder: recovers the {tom, notas} note code from a 7-segment
// pattern bus. Synchronizes and debounces the bus, detects each new stable
// pattern, decodes it against the xylophone segment map and hands the note
// to the consumer through a one-entry valid/ready buffer.
module xylo_seg_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic       note_valid,
  input  logic       note_ready,
  output logic       note_tom,
  output logic [2:0] note_notas,
  output logic       err_invalid,
  output logic       overflow
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [SEG_W-1:0] SEG_BLANK = SEG_W'(0);

  logic [SEG_W-1:0] sync1;
  logic [SEG_W-1:0] seg_s;
  logic [SEG_W-1:0] cand;
  logic [SEG_W-1:0] last;
  logic [CNT_W-1:0] cnt;

  logic             accept_c;
  logic             act_c;
  logic             hit_c;
  logic [IDX_W-1:0] idx_c;
  logic             load_ok_c;

  // Two-flop synchronizer for the asynchronous segment bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= SEG_BLANK;
      seg_s <= SEG_BLANK;
    end else begin
      sync1 <= seg_in;
      seg_s <= sync1;
    end
  end

  // Accept fires on the edge where the hold count reaches STABLE_CYCLES
  always_comb begin
    accept_c = 1'b0;
    if (seg_s != cand) begin
      accept_c = (CNT_MAX == CNT_W'(1));
    end else if (cnt < CNT_MAX) begin
      accept_c = ((cnt + CNT_W'(1)) == CNT_MAX);
    end
    act_c     = accept_c && (seg_s != last);
    load_ok_c = !note_valid || note_ready;
  end

  // Segment map lookup; 0x72 is shared by indices 9 and 11 and always yields 9
  always_comb begin
    hit_c = 1'b1;
    idx_c = IDX_W'(0);
    case (seg_s)
      7'h7F: idx_c = IDX_W'(0);
      7'h2A: idx_c = IDX_W'(1);
      7'h09: idx_c = IDX_W'(2);
      7'h0B: idx_c = IDX_W'(3);
      7'h36: idx_c = IDX_W'(4);
      7'h29: idx_c = IDX_W'(5);
      7'h0C: idx_c = IDX_W'(6);
      7'h1C: idx_c = IDX_W'(7);
      7'h77: idx_c = IDX_W'(8);
      7'h72: idx_c = IDX_W'(9);
      7'h42: idx_c = IDX_W'(10);
      7'h74: idx_c = IDX_W'(12);
      7'h51: idx_c = IDX_W'(13);
      7'h4E: idx_c = IDX_W'(14);
      7'h54: idx_c = IDX_W'(15);
      default: hit_c = 1'b0;
    endcase
  end

  // Stability filter; reset count is saturated so the reset blank raises no event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= SEG_BLANK;
      cnt  <= CNT_MAX;
    end else if (seg_s != cand) begin
      cand <= seg_s;
      cnt  <= CNT_W'(1);
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Edge detection: remember the last acted pattern, blanks included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SEG_BLANK;
    end else if (act_c) begin
      last <= seg_s;
    end
  end

  // One-entry output buffer with invalid/overflow pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_valid  <= 1'b0;
      note_tom    <= 1'b0;
      note_notas  <= 3'd0;
      err_invalid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      err_invalid <= 1'b0;
      overflow    <= 1'b0;
      if (note_valid && note_ready) begin
        note_valid <= 1'b0;
      end
      if (act_c && (seg_s != SEG_BLANK)) begin
        if (!hit_c) begin
          err_invalid <= 1'b1;
        end else if (load_ok_c) begin
          note_valid <= 1'b1;
          note_tom   <= idx_c[3];
          note_notas <= idx_c[2:0];
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/xylo_seg_encoder.md
# xylo_seg_encoder

Reverse-path encoder for the xylophone note display: watches a 7-segment pattern bus and recovers the `{tom, notas}` note code that produced it. The bus can be driven by the note-to-segment decoder or by an external panel.
- Synchronizes and debounces the pattern, then detects each new stable pattern.
- Looks the pattern up in the fixed 16-entry xylophone segment map.
- Delivers each recognized note once over a valid/ready handshake with a one-entry output buffer.
- Sits between the segment bus and the melody capture/playback logic.

## Interface
- STABLE_CYCLES, 4: consecutive synchronized cycles a pattern must hold before acceptance. Legal range 1..255; the counter is 8 bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment pattern, bit 6..0; asynchronous to clk.
- note_valid  out  1  output buffer holds a note.
- note_ready  in  1  consumer accepts the note this cycle.
- note_tom  out  1  recovered Tom bit.
- note_notas  out  3  recovered Notas code.
- err_invalid  out  1  one-cycle pulse: an accepted pattern is not in the map.
- overflow  out  1  one-cycle pulse: a valid note was dropped because the buffer was full.

## Operation
- Synchronizer: two flops on seg_in produce seg_s.
- Stability filter (registers cand[6:0], cnt[7:0]):
  - seg_s != cand: cand <= seg_s, cnt <= 1.
  - seg_s == cand and cnt < STABLE_CYCLES: cnt <= cnt+1.
  - An accept event fires on the edge where cnt becomes STABLE_CYCLES, including the load edge when STABLE_CYCLES = 1.
- Edge detection (register last[6:0]):
  - An accept event is acted on only if cand != last; last <= cand on every acted event.
  - The same note is therefore emitted once until a different stable pattern appears. Blank re-arms it.
- Action, applied to the acted pattern P:
  - P = 0x00 (blank/rest): no output, no pulse.
  - P in map: note = index. Index bit 3 is tom; bits 2:0 are notas.
  - P not in map: err_invalid = 1 for one cycle, no output.
- Map, index 0..15 (pattern hex, bit6 = MSB): 7F, 2A, 09, 0B, 36, 29, 0C, 1C, 77, 72, 42, 72, 74, 51, 4E, 54.
  - 0x72 is produced by both index 9 and index 11. It always decodes to index 9 (tom=1, notas=001); index 11 is unrecoverable.
- Output buffer:
  - A load is allowed when note_valid = 0, or when note_valid & note_ready in the same cycle. Simultaneous drain and load results in the new note, and note_valid stays 1.
  - If loading is not allowed: the note is dropped, the held note is unchanged, overflow = 1 for one cycle.
  - note_valid clears on note_valid & note_ready with no load.
  - note_tom and note_notas are stable while note_valid & !note_ready.

## Timing
- Reset values (async assert, synchronous deassert use): sync flops 0x00, cand 0x00, last 0x00, cnt = STABLE_CYCLES (no event from the reset blank), note_valid 0, note_tom 0, note_notas 0, err_invalid 0, overflow 0.
- Latency: pattern first sampled by sync flop 1 at edge 0 → note_valid, err_invalid or overflow asserted after edge STABLE_CYCLES+1 (edge 5 for the default).
- A change before cnt reaches STABLE_CYCLES restarts the filter, so glitches shorter than STABLE_CYCLES cycles produce no event.
- Handshake: transfer happens at the rising edge with note_valid & note_ready. note_ready may be high while note_valid is low, which is a no-op.
- Reset mid-operation: all state returns to reset values immediately. A held note is lost, and any partially filtered pattern is discarded.
- err_invalid and overflow are never asserted in the same cycle; each event is exactly one of: note, invalid, or dropped.

## Test plan
- Reset, then seg_in=0x00 held 20 cycles → note_valid, err_invalid and overflow all stay 0.
- STABLE_CYCLES=4, note_ready=1, seg_in 0x00→0x36 → note_valid=1 for one cycle, after edge 5 only, with tom=0, notas=100. Holding 0x36 for 50 cycles produces no second note.
- seg_in 0x4E, 0x00, 0x4E, each held 10 cycles, ready=1 → two notes: tom=1, notas=110 each time.
- seg_in=0x72 → tom=1, notas=001. seg_in=0x55 → err_invalid pulses once and note_valid stays 0.
- note_ready=0, present 0x7F, then 0x2A → first note held (tom=0, notas=000) and overflow pulses once for 0x2A. Then ready=1 in the same cycle a 0x09 accept fires → output becomes tom=0, notas=010 with note_valid continuously 1.
- Glitch and reset: 0x0B held 2 cycles inside 0x00 → no event. Assert rst_n=0 while a note is held → note_valid=0 asynchronously, and after release no stale note appears.
